datapath_seq: RTL and testbench

Parametrised successor to the Mini SRC bus datapath. It holds NREG general-purpose registers plus Y, Z (ZHI/ZLO), HI and LO on a single internal bus. A built-in T-state sequencer runs one register-to-register ALU instruction per `start`, so the control unit no longer hand-drives every `*in`/`*out` strobe. It includes a multi-cycle unsigned multiply/divide engine that writes HI/LO.

---
 rtl/datapath_seq_if.sv | 37 +++
 rtl/datapath_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: bundles the control, preload and debug signals of
// datapath_seq so the sequencer and its driver share one port.
//
//   master : drives start/op/rdst/rsrc1/rsrc2, ld_en/ld_sel/ld_data, rd_sel;
//            observes rd_data, hi_q, lo_q, busy, done, err.
//   slave  : the datapath itself (mirror directions).
interface datapath_seq_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int RAW   = $clog2(NREG)
);
  logic             start;
  logic [3:0]       op;
  logic [RAW-1:0]   rdst;
  logic [RAW-1:0]   rsrc1;
  logic [RAW-1:0]   rsrc2;
  logic             ld_en;
  logic [RAW-1:0]   ld_sel;
  logic [WIDTH-1:0] ld_data;
  logic [RAW-1:0]   rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, op, rdst, rsrc1, rsrc2, ld_en, ld_sel, ld_data, rd_sel,
    input  rd_data, hi_q, lo_q, busy, done, err
  );

  modport slave (
    input  start, op, rdst, rsrc1, rsrc2, ld_en, ld_sel, ld_data, rd_sel,
    output rd_data, hi_q, lo_q, busy, done, err
  );
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: single-bus register datapath (NREG GPRs, Y, ZHI/ZLO, HI, LO)
// with a T-state sequencer that runs one register-to-register instruction
// per start pulse.
//
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   ctl   : datapath_seq_if.slave (start/op/rdst/rsrc1/rsrc2, preload port,
//           debug read port, hi_q/lo_q, busy/done/err)
//
// Build option: define DATAPATH_SEQ_MULDIV_EN to compile in the iterative
// unsigned MUL/DIV engine (MD_ITER and T6). Without it, opcodes 8/9 are
// illegal and hi_q/lo_q read 0.
module datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int RAW   = $clog2(NREG)
) (
  input logic           clock,
  input logic           clear,
  datapath_seq_if.slave ctl
);
  localparam int SHW = $clog2(WIDTH);
  localparam int WM1 = WIDTH - 1;
  localparam logic [SHW:0] WBITS = WIDTH[SHW:0];

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  typedef enum logic [2:0] {
    IDLE, T3, T4, T5, DONE
`ifdef DATAPATH_SEQ_MULDIV_EN
    , MD_ITER, T6
`endif
  } state_t;

  state_t           state, next;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] y, zlo, bus, alu_out;
  // Operands are snapshotted at start so a preload in the same cycle
  // cannot leak into the instruction.
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [RAW-1:0]   rdst_q;
  logic             err_q, start_legal;
  logic [SHW-1:0]   shamt;
  logic [SHW:0]     rev_amt;

`ifdef DATAPATH_SEQ_MULDIV_EN
  localparam logic [SHW-1:0] CNT_INIT = WM1[SHW-1:0];
  logic [WIDTH-1:0] zhi, hi, lo;
  logic [SHW-1:0]   cnt;
  logic             op_md;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH+1:0] div_diff;
`endif

  always_comb begin
    start_legal = (ctl.op <= OP_ROL) || (ctl.op == OP_NEG) || (ctl.op == OP_NOT);
`ifdef DATAPATH_SEQ_MULDIV_EN
    if (ctl.op == OP_MUL || ctl.op == OP_DIV) start_legal = 1'b1;
`endif
  end

`ifdef DATAPATH_SEQ_MULDIV_EN
  // Multiplier lives in ZLO and shifts out LSB-first; the carry of each
  // partial sum shifts into ZHI. Divide keeps the remainder in ZHI and
  // shifts quotient bits into ZLO as the dividend shifts out.
  always_comb begin
    op_md    = (op_q == OP_MUL) || (op_q == OP_DIV);
    mul_sum  = {1'b0, zhi} + (zlo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_sh   = {zhi, zlo[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, b_q};
  end
`endif

  always_comb begin
    bus = '0;
    case (state)
      T3:      bus = a_q;
      T4:      bus = b_q;
      T5:      bus = zlo;
`ifdef DATAPATH_SEQ_MULDIV_EN
      T6:      bus = zhi;
`endif
      default: bus = '0;
    endcase
  end

  // Rotates are built from two shifts; a shift by WIDTH yields 0, which
  // makes a zero rotate amount come out right.
  always_comb begin
    shamt   = bus[SHW-1:0];
    rev_amt = WBITS - {1'b0, shamt};
    alu_out = '0;
    case (op_q)
      OP_ADD:  alu_out = y + bus;
      OP_SUB:  alu_out = y - bus;
      OP_AND:  alu_out = y & bus;
      OP_OR:   alu_out = y | bus;
      OP_SHR:  alu_out = y >> shamt;
      OP_SHL:  alu_out = y << shamt;
      OP_ROR:  alu_out = (y >> shamt) | (y << rev_amt);
      OP_ROL:  alu_out = (y << shamt) | (y >> rev_amt);
      OP_NEG:  alu_out = -bus;
      OP_NOT:  alu_out = ~bus;
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (ctl.start) next = start_legal ? T3 : DONE;
`ifdef DATAPATH_SEQ_MULDIV_EN
      T3:      next = op_md ? MD_ITER : T4;
      MD_ITER: if (cnt == '0) next = T5;
      T5:      next = op_md ? T6 : DONE;
      T6:      next = DONE;
`else
      T3:      next = T4;
      T5:      next = DONE;
`endif
      T4:      next = T5;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      y      <= '0;
      zlo    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rdst_q <= '0;
      err_q  <= 1'b0;
`ifdef DATAPATH_SEQ_MULDIV_EN
      zhi <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ctl.ld_en) regs[ctl.ld_sel] <= ctl.ld_data;
          if (ctl.start) begin
            op_q   <= ctl.op;
            rdst_q <= ctl.rdst;
            a_q    <= regs[ctl.rsrc1];
            b_q    <= regs[ctl.rsrc2];
            err_q  <= !start_legal;
          end
        end
        T3: begin
          y <= bus;
`ifdef DATAPATH_SEQ_MULDIV_EN
          if (op_md) begin
            zhi <= '0;
            zlo <= bus;
            cnt <= CNT_INIT;
          end
`endif
        end
        T4: zlo <= alu_out;
`ifdef DATAPATH_SEQ_MULDIV_EN
        MD_ITER: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            zhi <= mul_sum[WIDTH:1];
            zlo <= {mul_sum[0], zlo[WIDTH-1:1]};
          end else if (div_diff[WIDTH+1]) begin
            zhi <= rem_sh[WIDTH-1:0];
            zlo <= {zlo[WIDTH-2:0], 1'b0};
          end else begin
            zhi <= div_diff[WIDTH-1:0];
            zlo <= {zlo[WIDTH-2:0], 1'b1};
          end
        end
        T5: begin
          if (op_md) lo <= bus;
          else       regs[rdst_q] <= bus;
        end
        T6: hi <= bus;
`else
        T5: regs[rdst_q] <= bus;
`endif
        default: ;
      endcase
    end
  end

  assign ctl.rd_data = regs[ctl.rd_sel];
  assign ctl.busy    = (state != IDLE);
  assign ctl.done    = (state == DONE);
  assign ctl.err     = err_q && (state == DONE);
`ifdef DATAPATH_SEQ_MULDIV_EN
  assign ctl.hi_q = hi;
  assign ctl.lo_q = lo;
`else
  assign ctl.hi_q = '0;
  assign ctl.lo_q = '0;
`endif
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed scoreboard bench for datapath_seq (WIDTH=32,
// NREG=16). Stimulus pushes the hand-computed expected response for each
// instruction; an independent monitor pops and checks it on every done.
// Latency is measured in clock edges from the edge that samples start.
module tb_datapath_seq;
  localparam int WIDTH = 32;
  localparam int NREG  = 16;
  localparam int RAW   = 4;

`ifdef DATAPATH_SEQ_MULDIV_EN
  localparam bit MD_ON  = 1'b1;
  localparam int MD_LAT = WIDTH + 3;
`else
  localparam bit MD_ON  = 1'b0;
  localparam int MD_LAT = 0;
`endif

  typedef struct {
    string            name;
    logic [WIDTH-1:0] val;
    bit               chk_val;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    bit               chk_hilo;
    bit               err;
    int               lat;
    int               k;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [WIDTH-1:0] model [NREG];

  datapath_seq_if #(.WIDTH(WIDTH), .NREG(NREG), .RAW(RAW)) dif ();

  datapath_seq #(.WIDTH(WIDTH), .NREG(NREG), .RAW(RAW)) dut (
    .clock (clock),
    .clear (clear),
    .ctl   (dif)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (clear && dif.done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_err"}, WIDTH'(dif.err), WIDTH'(mon_e.err));
        checkOutput({mon_e.name, "_lat"}, WIDTH'(cyc - mon_e.k), WIDTH'(mon_e.lat));
        if (mon_e.chk_val) checkOutput({mon_e.name, "_val"}, dif.rd_data, mon_e.val);
        if (mon_e.chk_hilo) begin
          checkOutput({mon_e.name, "_hi"}, dif.hi_q, mon_e.hi);
          checkOutput({mon_e.name, "_lo"}, dif.lo_q, mon_e.lo);
        end
      end
    end
  end

  task automatic preload(input int sel, input logic [WIDTH-1:0] data);
    @(negedge clock);
    dif.ld_en   = 1'b1;
    dif.ld_sel  = RAW'(sel);
    dif.ld_data = data;
    @(negedge clock);
    dif.ld_en = 1'b0;
    model[sel] = data;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    @(negedge clock);
    while ((dif.busy || dif.done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_idle"}, WIDTH'(dif.busy), '0);
  endtask

  task automatic pushExp(input string name, input logic [WIDTH-1:0] val, input bit chk_val,
                         input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo,
                         input bit chk_hilo, input bit err, input int lat);
    exp_t e;
    e.name = name; e.val = val; e.chk_val = chk_val; e.hi = hi; e.lo = lo;
    e.chk_hilo = chk_hilo; e.err = err; e.lat = lat; e.k = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic setInstr(input logic [3:0] op, input int rd, input int r1, input int r2);
    dif.start = 1'b1;
    dif.op    = op;
    dif.rdst  = RAW'(rd);
    dif.rsrc1 = RAW'(r1);
    dif.rsrc2 = RAW'(r2);
    dif.rd_sel = RAW'(rd);
  endtask

  task automatic applyStimulus(input string name, input logic [3:0] op, input int rd,
                               input int r1, input int r2, input logic [WIDTH-1:0] val,
                               input bit chk_val, input logic [WIDTH-1:0] hi,
                               input logic [WIDTH-1:0] lo, input bit chk_hilo,
                               input bit err, input int lat);
    @(negedge clock);
    pushExp(name, val, chk_val, hi, lo, chk_hilo, err, lat);
    setInstr(op, rd, r1, r2);
    @(negedge clock);
    dif.start = 1'b0;
    if (chk_val) model[rd] = val;
    waitIdle(name);
  endtask

  task automatic checkAllRegs(input string name);
    for (int i = 0; i < NREG; i++) begin
      dif.rd_sel = RAW'(i);
      #1;
      checkOutput($sformatf("%s_r%0d", name, i), dif.rd_data, model[i]);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dif.start = 0; dif.op = 0; dif.rdst = 0; dif.rsrc1 = 0; dif.rsrc2 = 0;
    dif.ld_en = 0; dif.ld_sel = 0; dif.ld_data = 0; dif.rd_sel = 0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) @(negedge clock);
    checkOutput("rst_busy", WIDTH'(dif.busy), '0);
    checkOutput("rst_done", WIDTH'(dif.done), '0);
    checkOutput("rst_err",  WIDTH'(dif.err),  '0);
    checkOutput("rst_hi", dif.hi_q, '0);
    checkOutput("rst_lo", dif.lo_q, '0);
    clear = 1'b1;

    preload(1, 32'd5);
    preload(2, 32'd7);
    applyStimulus("add", 4'd0, 3, 1, 2, 32'd12, 1, 0, 0, 0, 0, 3);
    preload(1, 32'hFFFF_FFFF);
    applyStimulus("add_alias", 4'd0, 1, 1, 1, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 3);
    preload(2, 32'd33);
    applyStimulus("rol", 4'd7, 4, 1, 2, 32'hFFFF_FFFD, 1, 0, 0, 0, 0, 3);
    applyStimulus("sub", 4'd1, 5, 3, 2, 32'hFFFF_FFEB, 1, 0, 0, 0, 0, 3);
    applyStimulus("and", 4'd2, 6, 1, 3, 32'h0000_000C, 1, 0, 0, 0, 0, 3);
    applyStimulus("or",  4'd3, 7, 3, 2, 32'h0000_002D, 1, 0, 0, 0, 0, 3);
    applyStimulus("shr", 4'd4, 8, 1, 2, 32'h7FFF_FFFF, 1, 0, 0, 0, 0, 3);
    applyStimulus("shl", 4'd5, 9, 3, 2, 32'h0000_0018, 1, 0, 0, 0, 0, 3);
    applyStimulus("ror", 4'd6, 10, 2, 2, 32'h8000_0010, 1, 0, 0, 0, 0, 3);
    applyStimulus("neg", 4'd10, 11, 0, 3, 32'hFFFF_FFF4, 1, 0, 0, 0, 0, 3);
    applyStimulus("not", 4'd11, 12, 0, 3, 32'hFFFF_FFF3, 1, 0, 0, 0, 0, 3);

    // start and preload in the same IDLE cycle: instruction sees old R3=12
    @(negedge clock);
    pushExp("collide", 32'd24, 1, 0, 0, 0, 0, 3);
    setInstr(4'd0, 13, 3, 3);
    dif.ld_en = 1'b1; dif.ld_sel = 4'd3; dif.ld_data = 32'd100;
    @(negedge clock);
    dif.start = 1'b0; dif.ld_en = 1'b0;
    model[3] = 32'd100; model[13] = 32'd24;
    waitIdle("collide");
    dif.rd_sel = 4'd3;
    #1 checkOutput("collide_ld", dif.rd_data, 32'd100);

    // start and ld_en while busy are ignored
    @(negedge clock);
    pushExp("busy_ign", 32'd200, 1, 0, 0, 0, 0, 3);
    setInstr(4'd0, 14, 3, 3);
    @(negedge clock);
    setInstr(4'd1, 15, 3, 3);
    dif.rd_sel = 4'd14;
    dif.ld_en = 1'b1; dif.ld_sel = 4'd15; dif.ld_data = 32'hDEAD_BEEF;
    @(negedge clock);
    dif.start = 1'b0; dif.ld_en = 1'b0;
    model[14] = 32'd200;
    waitIdle("busy_ign");
    repeat (6) @(negedge clock);
    dif.rd_sel = 4'd15;
    #1 checkOutput("busy_ign_r15", dif.rd_data, '0);

    preload(1, 32'hFFFF_FFFF);
    preload(2, 32'hFFFF_FFFF);
    applyStimulus("mul", 4'd8, 0, 1, 2, 0, 0,
                  MD_ON ? 32'hFFFF_FFFE : 32'h0, MD_ON ? 32'h1 : 32'h0, 1, !MD_ON, MD_LAT);
    preload(1, 32'd100);
    preload(2, 32'd7);
    applyStimulus("div", 4'd9, 0, 1, 2, 0, 0,
                  MD_ON ? 32'd2 : 32'h0, MD_ON ? 32'd14 : 32'h0, 1, !MD_ON, MD_LAT);
    preload(1, 32'd9);
    preload(2, 32'd0);
    applyStimulus("div0", 4'd9, 0, 1, 2, 0, 0,
                  MD_ON ? 32'd9 : 32'h0, MD_ON ? 32'hFFFF_FFFF : 32'h0, 1, !MD_ON, MD_LAT);

    applyStimulus("illegal", 4'd13, 3, 1, 2, 0, 0,
                  MD_ON ? 32'd9 : 32'h0, MD_ON ? 32'hFFFF_FFFF : 32'h0, 1, 1, 0);
    checkAllRegs("illegal");

    // clear mid-instruction: MD_ITER when the engine exists, else T4
    @(negedge clock);
    setInstr(MD_ON ? 4'd8 : 4'd0, 5, 1, 2);
    @(negedge clock);
    dif.start = 1'b0;
    repeat (MD_ON ? 4 : 1) @(negedge clock);
    clear = 1'b0;
    #1;
    checkOutput("abort_busy", WIDTH'(dif.busy), '0);
    checkOutput("abort_hi", dif.hi_q, '0);
    checkOutput("abort_lo", dif.lo_q, '0);
    for (int i = 0; i < NREG; i++) model[i] = '0;
    checkAllRegs("abort");
    @(negedge clock);
    clear = 1'b1;
    preload(1, 32'd3);
    preload(2, 32'd4);
    applyStimulus("add_after", 4'd0, 5, 1, 2, 32'd7, 1, 0, 0, 0, 0, 3);

    repeat (4) @(negedge clock);
    checkOutput("sb_empty", WIDTH'(sb.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
